matvec_loop_seq: RTL and testbench
==================================

Name: matvec_loop_seq

Overview:
- Two-level loop sequencer for the matrix-vector datapath.
- Walks row index i over 0..num_rows-1 and column index j over 0..num_cols-1.
- Issues one element beat per accepted handshake, with a linear element address and first/last-of-row markers.
- After each row it waits for the datapath to acknowledge accumulator write-back, then advances; it signals completion with a one-cycle done pulse.

Parameters:
SIZE_ADDR, 8, width of row/column indices and of the count inputs
SIZE_LIN, 2*SIZE_ADDR, width of the linear element address

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  start pulse; sampled in IDLE or DONE only
i_clear  input  1  synchronous abort to IDLE, no done pulse
i_num_rows  input  SIZE_ADDR  row count, latched on accepted start
i_num_cols  input  SIZE_ADDR  column count, latched on accepted start
i_ready  input  1  datapath accepts the current beat
i_row_ack  input  1  datapath has finished the current row write-back
o_valid  output  1  beat valid (ISSUE state)
o_row  output  SIZE_ADDR  current row index
o_col  output  SIZE_ADDR  current column index
o_addr  output  SIZE_LIN  linear element address, row*num_cols+col
o_first  output  1  o_valid and col==0 (accumulator clear)
o_last  output  1  o_valid and col==num_cols-1
o_busy  output  1  state != IDLE
o_done  output  1  one-cycle completion pulse

Behaviour:
- Reset values: all outputs 0; state IDLE; latched counts 0.
- States: IDLE, ISSUE, WAIT_ROW, DONE. All outputs are decoded from registered state and counters; no combinational path from inputs to outputs.
- IDLE or DONE with i_start=1:
  - Latch both counts and clear row, col and addr to 0.
  - If either count is 0, go to DONE; o_done is asserted the next cycle.
  - Otherwise go to ISSUE; o_valid is asserted the cycle after start.
- ISSUE:
  - o_valid=1. A beat is accepted when i_ready=1.
  - On an accepted beat, addr increments by 1 and wraps modulo 2^SIZE_LIN.
  - If col < num_cols-1: col increments.
  - If col == num_cols-1: go to WAIT_ROW and hold row/col.
  - With i_ready=0, all outputs hold.
- WAIT_ROW:
  - o_valid=0. On i_row_ack=1:
    - If row == num_rows-1: go to DONE.
    - Otherwise row increments, col resets to 0, go to ISSUE.
  - i_row_ack is ignored in every other state.
- DONE:
  - o_done=1 for exactly one cycle, then IDLE.
  - i_start in DONE restarts (back-to-back runs); o_done still pulses that cycle.
- i_start in ISSUE or WAIT_ROW is ignored. Counts are not re-sampled mid-run.
- i_clear has priority over all transitions in every state: next state IDLE, row/col/addr cleared to 0, o_done stays 0.
- i_clear and i_start in the same cycle: i_clear wins.
- Asynchronous reset mid-run: immediate return to reset values, no done pulse.
- Max counts (2^SIZE_ADDR-1) must not overflow the index counters. The last index is compared against count-1, so no index wrap occurs.
- Total accepted beats per run = num_rows*num_cols. Minimum run latency, start to done with i_ready and i_row_ack tied high = rows*(cols+1)+2 cycles.

Optional Feature:
- Macro MATVEC_LOOP_SEQ_STALL_CNT_EN.
- Defined:
  - Adds output o_stall_cnt, width 2*SIZE_ADDR.
  - Counts cycles in ISSUE with i_ready=0 plus cycles in WAIT_ROW with i_row_ack=0.
  - Cleared on accepted start, on i_clear and on reset; saturates at all-ones.
  - Holds its value after DONE until the next start.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- rows=2, cols=3, i_ready=1, i_row_ack=1 -> beats (0,0,a0)(0,1,a1)(0,2,a2)(1,0,a3)(1,1,a4)(1,2,a5). o_first at cols 0, o_last at col 2. o_done pulses once at cycle 10 after start.
- rows=3, cols=0 -> no o_valid; o_done one cycle after start; o_busy high for exactly 1 cycle.
- rows=1, cols=4, i_ready toggling 1,0,1,0... -> o_row/o_col/o_addr held on ready-low cycles; 4 accepted beats; with the macro defined, o_stall_cnt=3 (plus any row-ack wait cycles).
- rows=2, cols=2, i_row_ack delayed 5 cycles -> o_valid low for 5 cycles in WAIT_ROW, then row=1 col=0 issued; done after the second ack.
- Mid-run i_clear at the beat (1,1) of rows=3, cols=3 -> IDLE next cycle, outputs 0, no o_done. A following start with rows=1, cols=1 completes normally.
- i_start pulses during ISSUE, and i_start asserted in the DONE cycle -> the first is ignored; the second launches a new run immediately with new counts latched.

Source files
------------

// File: rtl/matvec_loop_seq.sv
// Two-level row/column loop sequencer for the matrix-vector datapath.
// Optional stall-cycle counter output enabled by defining MATVEC_LOOP_SEQ_STALL_CNT_EN.
module matvec_loop_seq #(
  parameter int SIZE_ADDR = 8,
  parameter int SIZE_LIN  = 2 * SIZE_ADDR
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_clear,
  input  logic [SIZE_ADDR-1:0] i_num_rows,
  input  logic [SIZE_ADDR-1:0] i_num_cols,
  input  logic                 i_ready,
  input  logic                 i_row_ack,
  output logic                 o_valid,
  output logic [SIZE_ADDR-1:0] o_row,
  output logic [SIZE_ADDR-1:0] o_col,
  output logic [SIZE_LIN-1:0]  o_addr,
  output logic                 o_first,
  output logic                 o_last,
  output logic                 o_busy,
  output logic                 o_done
`ifdef MATVEC_LOOP_SEQ_STALL_CNT_EN
  ,
  output logic [2*SIZE_ADDR-1:0] o_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_ROW = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SIZE_ADDR-1:0] r_rows;
  logic [SIZE_ADDR-1:0] r_cols;
  logic [SIZE_ADDR-1:0] r_row;
  logic [SIZE_ADDR-1:0] r_col;
  logic [SIZE_LIN-1:0]  r_addr;

  logic w_start_ok;
  logic w_load;
  logic w_beat;
  logic w_row_adv;
  logic w_last_col;
  logic w_last_row;

  // Comparing against count-1 keeps indices below the count, so max counts never wrap.
  assign w_last_col = (r_col == r_cols - SIZE_ADDR'(1));
  assign w_last_row = (r_row == r_rows - SIZE_ADDR'(1));
  assign w_start_ok = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_beat      = 1'b0;
    w_row_adv   = 1'b0;
    if (i_clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_ok) begin
            w_load = 1'b1;
            if ((i_num_rows == '0) || (i_num_cols == '0)) w_state_nxt = S_DONE;
            else                                          w_state_nxt = S_ISSUE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_ISSUE: begin
          if (i_ready) begin
            w_beat = 1'b1;
            if (w_last_col) w_state_nxt = S_WAIT_ROW;
          end
        end
        S_WAIT_ROW: begin
          if (i_row_ack) begin
            if (w_last_row) begin
              w_state_nxt = S_DONE;
            end else begin
              w_row_adv   = 1'b1;
              w_state_nxt = S_ISSUE;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rows <= '0;
      r_cols <= '0;
      r_row  <= '0;
      r_col  <= '0;
      r_addr <= '0;
    end else if (i_clear) begin
      r_row  <= '0;
      r_col  <= '0;
      r_addr <= '0;
    end else if (w_load) begin
      r_rows <= i_num_rows;
      r_cols <= i_num_cols;
      r_row  <= '0;
      r_col  <= '0;
      r_addr <= '0;
    end else begin
      if (w_beat) begin
        r_addr <= r_addr + SIZE_LIN'(1);
        if (!w_last_col) r_col <= r_col + SIZE_ADDR'(1);
      end
      if (w_row_adv) begin
        r_row <= r_row + SIZE_ADDR'(1);
        r_col <= '0;
      end
    end
  end

`ifdef MATVEC_LOOP_SEQ_STALL_CNT_EN
  logic [2*SIZE_ADDR-1:0] r_stall_cnt;
  logic                   w_stall;

  assign w_stall = ((r_state == S_ISSUE) && !i_ready) ||
                   ((r_state == S_WAIT_ROW) && !i_row_ack);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (i_clear || w_load) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + (2*SIZE_ADDR)'(1);
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

  assign o_valid = (r_state == S_ISSUE);
  assign o_row   = r_row;
  assign o_col   = r_col;
  assign o_addr  = r_addr;
  assign o_first = o_valid && (r_col == '0);
  assign o_last  = o_valid && w_last_col;
  assign o_busy  = (r_state != S_IDLE);
  assign o_done  = (r_state == S_DONE);

endmodule

// File: tb/tb_matvec_loop_seq.sv
// Directed self-checking bench for matvec_loop_seq.
module tb_matvec_loop_seq;

  localparam int SA = 8;
  localparam int SL = 2 * SA;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_start;
  logic          i_clear;
  logic [SA-1:0] i_num_rows;
  logic [SA-1:0] i_num_cols;
  logic          i_ready;
  logic          i_row_ack;
  logic          o_valid;
  logic [SA-1:0] o_row;
  logic [SA-1:0] o_col;
  logic [SL-1:0] o_addr;
  logic          o_first;
  logic          o_last;
  logic          o_busy;
  logic          o_done;
`ifdef MATVEC_LOOP_SEQ_STALL_CNT_EN
  logic [2*SA-1:0] o_stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  matvec_loop_seq #(.SIZE_ADDR(SA), .SIZE_LIN(SL)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_clear    (i_clear),
    .i_num_rows (i_num_rows),
    .i_num_cols (i_num_cols),
    .i_ready    (i_ready),
    .i_row_ack  (i_row_ack),
    .o_valid    (o_valid),
    .o_row      (o_row),
    .o_col      (o_col),
    .o_addr     (o_addr),
    .o_first    (o_first),
    .o_last     (o_last),
    .o_busy     (o_busy),
    .o_done     (o_done)
`ifdef MATVEC_LOOP_SEQ_STALL_CNT_EN
    ,
    .o_stall_cnt(o_stall_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic beat(input string tag, input int r, input int c, input int a, input int ncols);
    chk({tag, ".valid"}, 32'(o_valid), 32'd1);
    chk({tag, ".row"},   32'(o_row),   32'(r));
    chk({tag, ".col"},   32'(o_col),   32'(c));
    chk({tag, ".addr"},  32'(o_addr),  32'(a));
    chk({tag, ".first"}, 32'(o_first), 32'(c == 0));
    chk({tag, ".last"},  32'(o_last),  32'(c == ncols - 1));
    chk({tag, ".done"},  32'(o_done),  32'd0);
  endtask

  task automatic launch(input int rows, input int cols);
    i_num_rows = SA'(rows);
    i_num_cols = SA'(cols);
    i_start    = 1'b1;
    step();
    i_start    = 1'b0;
    cyc        = 1;
  endtask

  task automatic finish_done(input string tag);
    chk({tag, ".done"}, 32'(o_done), 32'd1);
    chk({tag, ".busy"}, 32'(o_busy), 32'd1);
    step();
    chk({tag, ".done_low"}, 32'(o_done), 32'd0);
    chk({tag, ".idle"},     32'(o_busy), 32'd0);
  endtask

  initial begin
    int b;
    i_rst_n    = 1'b0;
    i_start    = 1'b0;
    i_clear    = 1'b0;
    i_num_rows = '0;
    i_num_cols = '0;
    i_ready    = 1'b1;
    i_row_ack  = 1'b1;
    step();
    chk("rst.valid", 32'(o_valid), 32'd0);
    chk("rst.busy",  32'(o_busy),  32'd0);
    chk("rst.done",  32'(o_done),  32'd0);
    chk("rst.addr",  32'(o_addr),  32'd0);
    i_rst_n = 1'b1;
    step();

    // 2x3 with ready/ack high
    launch(2, 3);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 3; c++) begin
        beat("t1", r, c, r * 3 + c, 3);
        step();
      end
      chk("t1.wait_valid", 32'(o_valid), 32'd0);
      chk("t1.wait_busy",  32'(o_busy),  32'd1);
      step();
    end
    // start cycle counted as cycle 1, so done lands on cycle rows*(cols+1)+2
    chk("t1.latency", 32'(cyc + 1), 32'd10);
    finish_done("t1");

    // zero column count
    launch(3, 0);
    chk("t2.valid", 32'(o_valid), 32'd0);
    finish_done("t2");

    // ready toggling 1,0,1,0,...
    launch(1, 4);
    b = 0;
    for (int k = 0; k < 20 && b < 4; k++) begin
      i_ready = (k % 2 == 0);
      beat("t3", 0, b, b, 4);
      step();
      if (i_ready) b++;
    end
    chk("t3.beats", 32'(b), 32'd4);
    i_ready = 1'b1;
    chk("t3.wait_valid", 32'(o_valid), 32'd0);
    step();
`ifdef MATVEC_LOOP_SEQ_STALL_CNT_EN
    chk("t3.stall", 32'(o_stall_cnt), 32'd3);
`endif
    finish_done("t3");
`ifdef MATVEC_LOOP_SEQ_STALL_CNT_EN
    chk("t3.stall_hold", 32'(o_stall_cnt), 32'd3);
`endif

    // delayed row ack
    launch(2, 2);
    i_row_ack = 1'b0;
    beat("t4", 0, 0, 0, 2);
    step();
    beat("t4", 0, 1, 1, 2);
    step();
    for (int k = 0; k < 5; k++) begin
      i_row_ack = (k == 4);
      chk("t4.wait_valid", 32'(o_valid), 32'd0);
      chk("t4.wait_row",   32'(o_row),   32'd0);
      step();
    end
    beat("t4", 1, 0, 2, 2);
    step();
    beat("t4", 1, 1, 3, 2);
    step();
    chk("t4.wait2_valid", 32'(o_valid), 32'd0);
    step();
`ifdef MATVEC_LOOP_SEQ_STALL_CNT_EN
    chk("t4.stall", 32'(o_stall_cnt), 32'd4);
`endif
    finish_done("t4");

    // clear at beat (1,1) of 3x3
    launch(3, 3);
    for (int c = 0; c < 3; c++) begin
      beat("t5", 0, c, c, 3);
      step();
    end
    step();
    beat("t5", 1, 0, 3, 3);
    step();
    beat("t5", 1, 1, 4, 3);
    i_clear = 1'b1;
    i_start = 1'b1;
    step();
    i_clear = 1'b0;
    i_start = 1'b0;
    chk("t5.valid", 32'(o_valid), 32'd0);
    chk("t5.busy",  32'(o_busy),  32'd0);
    chk("t5.done",  32'(o_done),  32'd0);
    chk("t5.row",   32'(o_row),   32'd0);
    chk("t5.col",   32'(o_col),   32'd0);
    chk("t5.addr",  32'(o_addr),  32'd0);
`ifdef MATVEC_LOOP_SEQ_STALL_CNT_EN
    chk("t5.stall", 32'(o_stall_cnt), 32'd0);
`endif
    step();
    chk("t5.no_done", 32'(o_done), 32'd0);
    launch(1, 1);
    beat("t5b", 0, 0, 0, 1);
    step();
    step();
    finish_done("t5b");

    // start ignored mid-run, start in DONE restarts
    launch(2, 2);
    beat("t6", 0, 0, 0, 2);
    step();
    beat("t6", 0, 1, 1, 2);
    i_num_rows = 8'd5;
    i_num_cols = 8'd7;
    i_start    = 1'b1;
    step();
    i_start = 1'b0;
    chk("t6.wait_valid", 32'(o_valid), 32'd0);
    step();
    beat("t6", 1, 0, 2, 2);
    step();
    beat("t6", 1, 1, 3, 2);
    step();
    step();
    chk("t6.done", 32'(o_done), 32'd1);
    i_num_rows = 8'd1;
    i_num_cols = 8'd3;
    i_start    = 1'b1;
    step();
    i_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      beat("t6b", 0, c, c, 3);
      step();
    end
    step();
    finish_done("t6b");

    // asynchronous reset mid-run
    launch(2, 2);
    step();
    beat("t7", 0, 1, 1, 2);
    #2 i_rst_n = 1'b0;
    #1;
    chk("t7.valid", 32'(o_valid), 32'd0);
    chk("t7.busy",  32'(o_busy),  32'd0);
    chk("t7.col",   32'(o_col),   32'd0);
    chk("t7.addr",  32'(o_addr),  32'd0);
    #1 i_rst_n = 1'b1;
    step();
    chk("t7.no_done", 32'(o_done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
